// File: rtl/fir_mc_core_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_mc_core_if
// Description : Sample-in / result-out stream bundle for fir_mc_core.
//               master : the side that offers samples and accepts results
//               slave  : the FIR engine
//   in_valid/in_ready/in_ch/in_sample        : sample stream into the engine
//   out_valid/out_ready/out_ch/out_sample/out_sat : result stream out
// Revision    : 1.0  initial release
// ============================================================================
interface fir_mc_core_if #(
   parameter int DATA_W = 16,
   parameter int CH_W   = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [CH_W-1:0]   in_ch;
   logic [DATA_W-1:0] in_sample;
   logic              out_valid;
   logic              out_ready;
   logic [CH_W-1:0]   out_ch;
   logic [DATA_W-1:0] out_sample;
   logic              out_sat;

   modport master (
      output in_valid, in_ch, in_sample, out_ready,
      input  in_ready, out_valid, out_ch, out_sample, out_sat
   );

   modport slave (
      input  in_valid, in_ch, in_sample, out_ready,
      output in_ready, out_valid, out_ch, out_sample, out_sat
   );
endinterface
`default_nettype wire

// File: rtl/fir_mc_core.sv
`default_nettype none
// ============================================================================
// Module      : fir_mc_core
// Description : Multi-channel time-multiplexed sequential FIR engine. One
//               sample history per channel, shared coefficient bank, one MAC
//               per cycle, programmable arithmetic right shift, saturation
//               to DATA_W with a clip flag, valid/ready result with hold.
// Ports       : clk, rst_n (async assert, active low)
//               cfg_taps, cfg_shift       : latched on each accepted sample
//               coef_wr/_addr/_data       : coefficient bank write (IDLE only)
//               coef_err                  : one-cycle pulse for dropped write
//               strm (fir_mc_core_if.slave): sample in / result out streams
//               busy                      : engine not idle
// Build macro : FIR_ROUND_EN - round half up before the shift instead of
//               plain truncation.
// Revision    : 1.0  initial release
// ============================================================================
module fir_mc_core #(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter int ACC_W    = 40,
   parameter int MAX_TAPS = 32,
   parameter int TAPS_W   = 6,
   parameter int CH_W     = 2
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic [TAPS_W-1:0] cfg_taps,
   input  wire logic [5:0]        cfg_shift,
   input  wire logic              coef_wr,
   input  wire logic [TAPS_W-1:0] coef_wr_addr,
   input  wire logic [COEF_W-1:0] coef_wr_data,
   output logic                   coef_err,
   fir_mc_core_if.slave           strm,
   output logic                   busy
);

   localparam int CH     = 2**CH_W;
   localparam int IDX_W  = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [TAPS_W-1:0] MAX_T = TAPS_W'(MAX_TAPS);
   localparam logic signed [ACC_W-1:0] SAT_HI =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_LO =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nx;

   logic signed [DATA_W-1:0] r_hist [CH][MAX_TAPS];
   logic signed [COEF_W-1:0] r_coef [MAX_TAPS];

   logic [CH_W-1:0]          r_ch;
   logic [TAPS_W-1:0]        r_taps;
   logic [5:0]               r_shift;
   logic [TAPS_W-1:0]        r_idx;
   logic signed [ACC_W-1:0]  r_acc;
   logic [DATA_W-1:0]        r_out_sample;
   logic                     r_out_sat;
   logic                     r_coef_err;

   logic                     w_accept;
   logic                     w_in_ready;
   logic                     w_coef_ok;
   logic                     w_last;
   logic [TAPS_W-1:0]        w_taps_clamp;
   logic signed [DATA_W-1:0] w_hist_sel;
   logic signed [COEF_W-1:0] w_coef_sel;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_rnd;
   logic signed [ACC_W-1:0]  w_acc_rnd;
   logic signed [ACC_W-1:0]  w_scaled;
   logic                     w_sat_hi;
   logic                     w_sat_lo;
   logic [DATA_W-1:0]        w_res;

   assign w_in_ready   = (r_state == IDLE) && (cfg_taps != '0);
   assign w_accept     = strm.in_valid && w_in_ready;
   assign w_coef_ok    = (r_state == IDLE) && (coef_wr_addr < MAX_T);
   assign w_taps_clamp = (cfg_taps > MAX_T) ? MAX_T : cfg_taps;

   // idx runs 0..T-1 for the MACs; idx==T is the result-formatting cycle.
   assign w_last       = (r_idx == r_taps);

   assign w_hist_sel   = r_hist[r_ch][r_idx[IDX_W-1:0]];
   assign w_coef_sel   = r_coef[r_idx[IDX_W-1:0]];
   assign w_prod       = w_hist_sel * w_coef_sel;
   assign w_prod_ext   = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

`ifdef FIR_ROUND_EN
   assign w_rnd = (r_shift != 6'd0)
                ? ({{(ACC_W-1){1'b0}}, 1'b1} << (r_shift - 6'd1)) : '0;
`else
   assign w_rnd = '0;
`endif

   assign w_acc_rnd = r_acc + w_rnd;
   assign w_scaled  = w_acc_rnd >>> r_shift;
   assign w_sat_hi  = (w_scaled > SAT_HI);
   assign w_sat_lo  = (w_scaled < SAT_LO);
   assign w_res     = w_sat_hi ? SAT_HI[DATA_W-1:0] :
                      w_sat_lo ? SAT_LO[DATA_W-1:0] : w_scaled[DATA_W-1:0];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE:    if (w_accept)       w_state_nx = MAC;
         MAC:     if (w_last)         w_state_nx = OUT;
         OUT:     if (strm.out_ready) w_state_nx = IDLE;
         default:                     w_state_nx = IDLE;
      endcase
   end

   // ------------------------------------------------------ sample history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CH; c++)
            for (int k = 0; k < MAX_TAPS; k++)
               r_hist[c][k] <= '0;
      end else if (w_accept) begin
         for (int k = MAX_TAPS-1; k > 0; k--)
            r_hist[strm.in_ch][k] <= r_hist[strm.in_ch][k-1];
         r_hist[strm.in_ch][0] <= strm.in_sample;
      end
   end

   // ----------------------------------------------------- coefficient bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < MAX_TAPS; k++)
            r_coef[k] <= '0;
      end else if (coef_wr && w_coef_ok) begin
         r_coef[coef_wr_addr[IDX_W-1:0]] <= coef_wr_data;
      end
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch         <= '0;
         r_taps       <= '0;
         r_shift      <= '0;
         r_idx        <= '0;
         r_acc        <= '0;
         r_out_sample <= '0;
         r_out_sat    <= 1'b0;
         r_coef_err   <= 1'b0;
      end else begin
         r_coef_err <= coef_wr && !w_coef_ok;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_ch    <= strm.in_ch;
                  r_taps  <= w_taps_clamp;
                  r_shift <= cfg_shift;
                  r_acc   <= '0;
                  r_idx   <= '0;
               end
            end
            MAC: begin
               if (w_last) begin
                  r_out_sample <= w_res;
                  r_out_sat    <= w_sat_hi || w_sat_lo;
               end else begin
                  r_acc <= r_acc + w_prod_ext;
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign strm.in_ready   = w_in_ready;
   assign strm.out_valid  = (r_state == OUT);
   assign strm.out_ch     = r_ch;
   assign strm.out_sample = r_out_sample;
   assign strm.out_sat    = r_out_sat;
   assign busy            = (r_state != IDLE);
   assign coef_err        = r_coef_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_mc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mc_core
// Description : Directed, table-driven bench for fir_mc_core plus hand-written
//               sequences for tap clamp/zero, coefficient errors,
//               backpressure and reset during a computation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fir_mc_core;

   localparam int DATA_W   = 16;
   localparam int COEF_W   = 16;
   localparam int ACC_W    = 40;
   localparam int MAX_TAPS = 32;
   localparam int TAPS_W   = 6;
   localparam int CH_W     = 2;

`ifdef FIR_ROUND_EN
   localparam int R_P1 = 2;    //  3/2 -> 1.5 rounds to 2
   localparam int R_M1 = -1;   // -3/2 -> -1.5 rounds up to -1
   localparam int R_P6 = 5;    // 18/4 -> 4.5 rounds to 5
`else
   localparam int R_P1 = 1;
   localparam int R_M1 = -2;   // floor of -1.5
   localparam int R_P6 = 4;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [TAPS_W-1:0] cfg_taps;
   logic [5:0]        cfg_shift;
   logic              coef_wr;
   logic [TAPS_W-1:0] coef_wr_addr;
   logic [COEF_W-1:0] coef_wr_data;
   logic              coef_err;
   logic              busy;

   fir_mc_core_if #(.DATA_W(DATA_W), .CH_W(CH_W)) strm();

   fir_mc_core #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W),
      .MAX_TAPS(MAX_TAPS), .TAPS_W(TAPS_W), .CH_W(CH_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_taps(cfg_taps), .cfg_shift(cfg_shift),
      .coef_wr(coef_wr), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .coef_err(coef_err), .strm(strm), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int set;
      int ch;
      int sample;
      int taps;
      int shift;
      int exp;
      int sat;
   } vec_t;

   vec_t vecs [16];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int coef_of(input int set, input int i);
      case (set)
         0:       return (i < 4)  ? i + 1 : 0;
         1:       return (i < 2)  ? 1     : 0;
         2:       return (i < 2)  ? 32767 : 0;
         3:       return (i == 0) ? 3     : 0;
         default: return 0;
      endcase
   endfunction

   task automatic load_set(input int set);
      for (int i = 0; i < MAX_TAPS; i++) begin
         @(negedge clk);
         coef_wr      = 1'b1;
         coef_wr_addr = TAPS_W'(i);
         coef_wr_data = COEF_W'(coef_of(set, i));
      end
      @(negedge clk);
      coef_wr = 1'b0;
      check("coef_err_on_valid_write", int'(coef_err), 0);
   endtask

   // Offer one sample, then scramble cfg_* during the computation (they must
   // have been latched), wait for the result and take it.
   task automatic run_sample(input string tag, input int ch, input int sample,
                             input int taps, input int shift,
                             input int exp, input int exp_sat);
      int lat;
      int t_eff;
      @(negedge clk);
      cfg_taps  = TAPS_W'(taps);
      cfg_shift = 6'(shift);
      #1;
      check({tag, "_in_ready"}, int'(strm.in_ready), 1);
      strm.in_valid  = 1'b1;
      strm.in_ch     = CH_W'(ch);
      strm.in_sample = DATA_W'(sample);
      @(negedge clk);
      strm.in_valid = 1'b0;
      cfg_taps      = 6'd1;
      cfg_shift     = 6'd7;
      lat = 0;
      while (!strm.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      t_eff = (taps > MAX_TAPS) ? MAX_TAPS : taps;
      check({tag, "_latency"}, lat, t_eff + 1);
      check({tag, "_sample"}, int'($signed(strm.out_sample)), exp);
      check({tag, "_ch"}, int'(strm.out_ch), ch);
      check({tag, "_sat"}, int'(strm.out_sat), exp_sat);
      strm.out_ready = 1'b1;
      @(negedge clk);
      strm.out_ready = 1'b0;
      check({tag, "_idle_after"}, int'({strm.out_valid, busy}), 0);
   endtask

   initial begin
      int cur_set;
      int lat;
      int good;

      vecs[0]  = '{0, 0,      1,  4, 0,      1, 0};
      vecs[1]  = '{0, 0,      0,  4, 0,      2, 0};
      vecs[2]  = '{0, 0,      0,  4, 0,      3, 0};
      vecs[3]  = '{0, 0,      0,  4, 0,      4, 0};
      vecs[4]  = '{0, 0,      0,  4, 0,      0, 0};
      vecs[5]  = '{1, 1,     10,  2, 0,     10, 0};
      vecs[6]  = '{1, 2,      5,  2, 0,      5, 0};
      vecs[7]  = '{1, 1,     20,  2, 0,     30, 0};
      vecs[8]  = '{1, 2,      7, 40, 0,     12, 0};   // taps clamp to 32
      vecs[9]  = '{2, 3,  32767,  2, 0,  32767, 1};
      vecs[10] = '{2, 3,  32767,  2, 0,  32767, 1};
      vecs[11] = '{2, 3, -32768,  2, 0, -32767, 0};
      vecs[12] = '{2, 3, -32768,  2, 0, -32768, 1};
      vecs[13] = '{3, 0,      1,  1, 1,   R_P1, 0};
      vecs[14] = '{3, 0,     -1,  1, 1,   R_M1, 0};
      vecs[15] = '{3, 0,      6,  1, 2,   R_P6, 0};

      cfg_taps       = 6'd4;
      cfg_shift      = 6'd0;
      coef_wr        = 1'b0;
      coef_wr_addr   = '0;
      coef_wr_data   = '0;
      strm.in_valid  = 1'b0;
      strm.in_ch     = '0;
      strm.in_sample = '0;
      strm.out_ready = 1'b0;

      // ---- reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid",  int'(strm.out_valid), 0);
      check("rst_out_sample", int'(strm.out_sample), 0);
      check("rst_out_ch",     int'(strm.out_ch), 0);
      check("rst_out_sat",    int'(strm.out_sat), 0);
      check("rst_coef_err",   int'(coef_err), 0);
      check("rst_busy",       int'(busy), 0);
      check("rst_in_ready",   int'(strm.in_ready), 1);
      rst_n = 1'b1;

      // ---- table-driven vectors
      cur_set = -1;
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].set != cur_set) begin
            load_set(vecs[i].set);
            cur_set = vecs[i].set;
         end
         run_sample($sformatf("vec%0d", i), vecs[i].ch, vecs[i].sample,
                    vecs[i].taps, vecs[i].shift, vecs[i].exp, vecs[i].sat);
      end

      // ---- cfg_taps == 0 blocks input
      @(negedge clk);
      cfg_taps = 6'd0;
      strm.in_valid = 1'b1;
      #1;
      check("taps0_in_ready", int'(strm.in_ready), 0);
      repeat (3) @(negedge clk);
      check("taps0_busy", int'(busy), 0);
      strm.in_valid = 1'b0;

      // ---- out-of-range coefficient address
      load_set(1);
      @(negedge clk);
      coef_wr = 1'b1; coef_wr_addr = 6'd32; coef_wr_data = 16'd5;
      @(negedge clk);
      coef_wr = 1'b0;
      check("bad_addr_err_pulse", int'(coef_err), 1);
      @(negedge clk);
      check("bad_addr_err_clear", int'(coef_err), 0);

      // ---- coefficient write during MAC is dropped; ch1 hist [20,10] -> [1,20]
      cfg_taps = 6'd2; cfg_shift = 6'd0;
      strm.in_valid = 1'b1; strm.in_ch = 2'd1; strm.in_sample = 16'd1;
      @(negedge clk);
      strm.in_valid = 1'b0;
      coef_wr = 1'b1; coef_wr_addr = 6'd0; coef_wr_data = 16'd100;
      @(negedge clk);
      coef_wr = 1'b0;
      check("mac_wr_err_pulse", int'(coef_err), 1);
      lat = 0;
      while (!strm.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("mac_wr_result", int'($signed(strm.out_sample)), 21);
      strm.out_ready = 1'b1;
      @(negedge clk);
      strm.out_ready = 1'b0;
      run_sample("mac_wr_after", 1, 2, 2, 0, 3, 0);   // [2,1] with coef {1,1}

      // ---- backpressure; ch0 hist [6,-1,1,...] -> [2,6,-1,1] -> 15
      load_set(0);
      @(negedge clk);
      cfg_taps = 6'd4; cfg_shift = 6'd0;
      strm.in_valid = 1'b1; strm.in_ch = 2'd0; strm.in_sample = 16'd2;
      @(negedge clk);
      strm.in_valid = 1'b0;
      lat = 0;
      while (!strm.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("bp_result", int'($signed(strm.out_sample)), 15);
      good = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (strm.out_valid && !strm.in_ready && busy &&
             $signed(strm.out_sample) == 16'sd15 && strm.out_ch == 2'd0 &&
             !strm.out_sat)
            good++;
      end
      check("bp_hold_cycles", good, 10);
      strm.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", int'(strm.out_valid), 0);
      check("bp_release_busy", int'(busy), 0);
      @(negedge clk);
      strm.out_ready = 1'b0;
      check("bp_single_transfer", int'(strm.out_valid), 0);

      // ---- reset mid-MAC, then clean impulse response
      @(negedge clk);
      cfg_taps = 6'd4;
      strm.in_valid = 1'b1; strm.in_ch = 2'd0; strm.in_sample = 16'd9;
      @(negedge clk);
      strm.in_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_out_valid", int'(strm.out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      load_set(0);
      run_sample("post_rst_imp0", 0, 1, 4, 0, 1, 0);
      run_sample("post_rst_imp1", 0, 0, 4, 0, 2, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
